// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial sequencer for an external 1-bit full-adder cell.
// Operands are accepted on a valid/ready handshake. The adder is fed one bit
// pair per clock, LSB first, and its carry is chained back each cycle. The
// assembled sum and final carry are then offered on a valid/ready output.
// Optional macro SERIAL_ADD_SEQ_SUB_EN adds an in_sub port for a - b.
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef SERIAL_ADD_SEQ_SUB_EN
    input  logic             in_sub,
`endif
    output logic             fa_x,
    output logic             fa_y,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] out_sum_r;
    logic             out_cout_r;

    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic             last_bit;
    logic [WIDTH:0]   res_cat;
    logic [WIDTH-1:0] res_next;

    // Operand preparation: subtraction is a + ~b + 1 through the same cell.
`ifdef SERIAL_ADD_SEQ_SUB_EN
    assign b_load = in_sub ? ~in_b : in_b;
    assign c_load = in_sub ? 1'b1  : in_cin;
`else
    assign b_load = in_b;
    assign c_load = in_cin;
`endif

    // New sum bit enters at the MSB. The shift form also works for WIDTH=1.
    assign res_cat  = {fa_sum, res_sh} >> 1;
    assign res_next = res_cat[WIDTH-1:0];
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake/adder outputs; adder inputs come only from registers
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        fa_x      = 1'b0;
        fa_y      = 1'b0;
        fa_cin    = 1'b0;
        unique case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy   = 1'b1;
                fa_x   = a_sh[0];
                fa_y   = b_sh[0];
                fa_cin = carry;
                if (last_bit) state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand/result shifters, carry chain, bit counter, result hold
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            carry      <= 1'b0;
            cnt        <= '0;
            out_sum_r  <= '0;
            out_cout_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sh   <= in_a;
                        b_sh   <= b_load;
                        carry  <= c_load;
                        res_sh <= '0;
                        cnt    <= '0;
                    end
                end
                S_RUN: begin
                    res_sh <= res_next;
                    carry  <= fa_cout;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        out_sum_r  <= res_next;
                        out_cout_r <= fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_sum  = out_sum_r;
    assign out_cout = out_cout_r;

endmodule

// File: tb/tb_serial_add_seq.sv
// Bench for serial_add_seq (WIDTH=8) with an ideal full adder on fa_*.
module tb_serial_add_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_cin, out_ready;
    logic [W-1:0] in_a, in_b;
    logic         in_ready, fa_x, fa_y, fa_cin, fa_sum, fa_cout;
    logic         out_valid, out_cout, busy;
    logic [W-1:0] out_sum;
`ifdef SERIAL_ADD_SEQ_SUB_EN
    logic         in_sub;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Ideal full-adder cell
    assign fa_sum  = fa_x ^ fa_y ^ fa_cin;
    assign fa_cout = (fa_x & fa_y) | (fa_x & fa_cin) | (fa_y & fa_cin);

    serial_add_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef SERIAL_ADD_SEQ_SUB_EN
        .in_sub(in_sub),
`endif
        .fa_x(fa_x), .fa_y(fa_y), .fa_cin(fa_cin),
        .fa_sum(fa_sum), .fa_cout(fa_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
    );

    typedef struct {
        logic [W-1:0] a, b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation, wait for the result, then accept it.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, output logic [W-1:0] sum, output logic cout,
                          output int cyc, output logic [W-1:0] xtr, output logic [W-1:0] ctr);
        in_a = a; in_b = b; in_cin = cin;
`ifdef SERIAL_ADD_SEQ_SUB_EN
        in_sub = sub;
`else
        if (sub) $display("note: subtract requested in add-only build");
`endif
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("in_ready_drop", in_ready, 0);
        chk("busy_run", busy, 1);
        cyc = 0; xtr = '0; ctr = '0;
        while (!out_valid && cyc < 64) begin
            if (cyc < W) begin
                xtr[cyc] = fa_x;
                ctr[cyc] = fa_cin;
            end
            tick();
            cyc++;
        end
        sum  = out_sum;
        cout = out_cout;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("back_to_idle", {out_valid, in_ready, busy}, 3'b010);
    endtask

    initial begin
        vec_t         tbl[6];
        logic [W-1:0] s, xtr, ctr, ra, rb, hold_s;
        logic         c, rc, rs, hold_c;
        int           cyc;
        logic [W:0]   ref_v;

        rst = 1'b1; in_valid = 1'b0; in_cin = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0;
`ifdef SERIAL_ADD_SEQ_SUB_EN
        in_sub = 1'b0;
`endif
        tick(); tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_cout", out_cout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fa", {fa_x, fa_y, fa_cin}, 0);
        rst = 1'b0;
        tick();

        // Directed table
        tbl[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        tbl[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        tbl[5] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0, s, c, cyc, xtr, ctr);
            chk($sformatf("tbl%0d_latency", i), cyc, W);
            chk($sformatf("tbl%0d_sum", i), s, tbl[i].sum);
            chk($sformatf("tbl%0d_cout", i), c, tbl[i].cout);
            if (i == 0) chk("fa_x_seq", xtr, 8'h5A);
            if (i == 1) chk("fa_cin_ripple", ctr, 8'hFE);
        end

        // Backpressure: result held, new operands ignored
        run_op(8'h12, 8'h34, 1'b0, 1'b0, s, c, cyc, xtr, ctr);
        chk("pre_bp_sum", s, 8'h46);
        in_a = 8'h12; in_b = 8'h34; in_cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 64) begin tick(); cyc++; end
        chk("bp_latency", cyc, W);
        in_valid = 1'b1; in_a = 8'hAA; in_b = 8'h55;
        for (int i = 0; i < 20; i++) begin
            chk("bp_hold", {out_valid, in_ready, busy, out_cout, out_sum}, {4'b1010, 8'h46});
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("bp_release", {out_valid, in_ready}, 2'b01);
        chk("bp_sum_kept", out_sum, 8'h46);
        tick();

        // Mid-operation reset on the 4th RUN cycle
        in_a = 8'hF0; in_b = 8'h0F; in_cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_state", {in_ready, out_valid, busy}, 3'b100);
        chk("midrst_out", {out_cout, out_sum}, 0);
        chk("midrst_fa", {fa_x, fa_y, fa_cin}, 0);
        for (int i = 0; i < 12; i++) begin
            if (out_valid) chk("midrst_no_emit", out_valid, 0);
            tick();
        end
        run_op(8'h10, 8'h20, 1'b0, 1'b0, s, c, cyc, xtr, ctr);
        chk("post_rst_sum", {c, s}, 9'h030);

`ifdef SERIAL_ADD_SEQ_SUB_EN
        run_op(8'h0A, 8'h03, 1'b0, 1'b1, s, c, cyc, xtr, ctr);
        chk("sub_pos", {c, s}, {1'b1, 8'h07});
        run_op(8'h03, 8'h0A, 1'b1, 1'b1, s, c, cyc, xtr, ctr);
        chk("sub_neg", {c, s}, {1'b0, 8'hF9});
`endif

        // Random operations against arithmetic reference
        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
`ifdef SERIAL_ADD_SEQ_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            run_op(ra, rb, rc, rs, s, c, cyc, xtr, ctr);
            if (rs) begin
                hold_s = ra - rb;
                hold_c = (ra >= rb);
                ref_v  = {hold_c, hold_s};
            end else begin
                ref_v = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            end
            chk($sformatf("rnd%0d_latency", i), cyc, W);
            chk($sformatf("rnd%0d_result", i), {c, s}, ref_v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
